seq_mult_unit: RTL

//   Iterative unsigned WIDTHxWIDTH shift-and-add multiplier for the datapath's MUL path.

---
 rtl/seq_mult_if.sv | 14 +
 rtl/seq_mult_unit.sv | 87 ++++++++
 2 files changed

// File: rtl/seq_mult_if.sv
// Handshake bundle between the control FSM (master) and the iterative multiplier (slave).
interface seq_mult_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_unit.sv
// Iterative unsigned shift-and-add multiplier: one partial product per clock,
// WIDTH iterations per op, start/busy/done handshake toward the control FSM.
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_mult_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // State bit 0 is busy and bit 1 is done, so both outputs come straight off flops.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]           state_q,   state_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [CW-1:0]        count_q,   count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step;

    // Ripple-carry adder slot, Cin=0; result is {Cout, Sum}.
    function automatic logic [WIDTH:0] rca_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Carry-out lands in the top bit before the shift, so nothing overflows.
    always_comb begin
        sum      = rca_add(acc_q[2*WIDTH-1:WIDTH], mcand_q);
        acc_step = acc_q[0] ? {sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            S_RUN: begin
                acc_d   = acc_step;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    product_d = acc_step;
                    state_d   = S_DONE;
                end
            end
            default: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    acc_d   = {{WIDTH{1'b0}}, bus.b};
                    count_d = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = state_q[0];
    assign bus.done    = state_q[1];
    assign bus.product = product_q;
endmodule
